// File: rtl/fifo_rd_packer_if.sv
// Stream bundle between the packer, the read side of the byte FIFO and the
// downstream word consumer.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
);
  logic                    fifo_empty;
  logic [WIDTH-1:0]        fifo_data;
  logic                    read_en;
  logic                    flush;
  logic [WIDTH*PACK-1:0]   out_data;
  logic [PACK-1:0]         out_keep;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             word_count;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output read_en, out_data, out_keep, out_valid, word_count
  );

  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  read_en, out_data, out_keep, out_valid, word_count
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the clock-crossing FIFO, packs PACK of them into one word and
// offers it on a valid/ready stream; a flush pushes out a partial word with a lane mask.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) (
  input logic               clk_read,
  input logic               rst,
  fifo_rd_packer_if.master  bus
);
  localparam int CW = $clog2(PACK + 1);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t                     state;
  state_t                     state_next;
  logic [CW-1:0]              lane_cnt;
  logic                       rd_pend;
  logic [PACK-1:0][WIDTH-1:0] acc;
  logic [CW:0]                occupancy;
  logic                       slot_free;
  logic                       emit;
  logic [WIDTH*PACK-1:0]      emit_data;
  logic [PACK-1:0]            emit_keep;

  // A byte still in flight already owns a lane, so it counts against capacity.
  assign occupancy    = {1'b0, lane_cnt} + {{CW{1'b0}}, rd_pend};
  assign bus.read_en  = !rst && !bus.fifo_empty && (state == FILL) &&
                        (occupancy < (CW+1)'(PACK));
  assign slot_free    = !bus.out_valid || bus.out_ready;

  always_comb begin
    emit       = 1'b0;
    state_next = state;
    case (state)
      FILL: begin
        if ((lane_cnt == CW'(PACK)) && slot_free) emit = 1'b1;
        if (bus.flush) state_next = FLUSH;
      end
      FLUSH: begin
        if ((lane_cnt != '0) && !rd_pend && slot_free) begin
          emit       = 1'b1;
          state_next = FILL;
        end else if ((lane_cnt == '0) && !rd_pend) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Lanes beyond lane_cnt may hold bytes of an older word and are zeroed.
  always_comb begin
    emit_keep = '0;
    emit_data = '0;
    for (int i = 0; i < PACK; i++) begin
      emit_keep[i]                 = (CW'(i) < lane_cnt);
      emit_data[i*WIDTH +: WIDTH]  = emit_keep[i] ? acc[i] : '0;
    end
  end

  always_ff @(posedge clk_read) begin
    if (rst) begin
      state          <= FILL;
      lane_cnt       <= '0;
      rd_pend        <= 1'b0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_keep   <= '0;
      bus.word_count <= '0;
    end else begin
      state   <= state_next;
      rd_pend <= bus.read_en;
      if (emit) begin
        lane_cnt <= '0;
      end else if (rd_pend) begin
        lane_cnt <= lane_cnt + CW'(1);
      end
      for (int i = 0; i < PACK; i++) begin
        if (rd_pend && (lane_cnt == CW'(i))) acc[i] <= bus.fifo_data;
      end
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= emit_data;
        bus.out_keep  <= emit_keep;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (bus.out_valid && bus.out_ready) bus.word_count <= bus.word_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: table vectors, hand-built corner sequences
// and a randomized run compared against a byte-grouping reference model.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int PACK  = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  typedef struct {
    int          nbytes;
    logic [31:0] bytes;
    bit          do_flush;
    int          exp_words;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  logic clk_read = 1'b0;
  logic rst;

  fifo_rd_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
    .clk_read (clk_read),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_read = ~clk_read;

  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          exp_wc = 0;
  bit          pop_req = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic [7:0]  fifo_q[$];
  word_t       rx_q[$];
  vec_t        vecs[6];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Observes the DUT mid-cycle: pop requests, accepted words and held words.
  always @(negedge clk_read) begin
    pop_req = bus.read_en;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("hold_valid", bus.out_valid, 1);
        check_output("hold_word", {bus.out_keep, bus.out_data}, {prev_keep, prev_data});
      end
      if (bus.read_en) rd_pulses++;
      if (bus.out_valid && bus.out_ready) begin
        word_t w;
        w.data = bus.out_data;
        w.keep = bus.out_keep;
        rx_q.push_back(w);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
    end
  end

  // FIFO read side: data appears one cycle after the pop request.
  task automatic tick();
    @(posedge clk_read);
    #1;
    if (pop_req) begin
      check_output("no_underflow", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] b;
    b = v.bytes;
    for (int k = 0; k < v.nbytes; k++) push(b[8*k +: 8]);
    run(12);
    if (v.do_flush) begin
      pulse_flush();
      run(6);
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] data,
                            input logic [3:0] keep);
    if (rx_q.size() > idx) begin
      check_output(name, {rx_q[idx].keep, rx_q[idx].data}, {keep, data});
    end else begin
      check_output({name, "_missing"}, rx_q.size(), idx + 1);
    end
  endtask

  initial begin
    int          base_rd;
    logic [7:0]  exp_bytes[$];
    int          n_exp;
    logic [31:0] d;
    logic [3:0]  kp;
    logic [7:0]  rb;

    vecs[0] = '{4, 32'h95CCBBAA, 1'b0, 1, 32'h95CCBBAA, 4'hF};
    vecs[1] = '{1, 32'h0000000B, 1'b1, 1, 32'h0000000B, 4'h1};
    vecs[2] = '{0, 32'h00000000, 1'b1, 0, 32'h00000000, 4'h0};
    vecs[3] = '{2, 32'h00003412, 1'b1, 1, 32'h00003412, 4'h3};
    vecs[4] = '{3, 32'h00776655, 1'b1, 1, 32'h00776655, 4'h7};
    vecs[5] = '{4, 32'hDEADBEEF, 1'b1, 1, 32'hDEADBEEF, 4'hF};

    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    rst            = 1'b1;
    push(8'h5A);
    run(2);
    check_output("rst_read_en", bus.read_en, 0);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_data", bus.out_data, 0);
    check_output("rst_out_keep", bus.out_keep, 0);
    check_output("rst_word_count", bus.word_count, 0);
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      base_rd = rd_pulses;
      apply_stimulus(vecs[i]);
      exp_wc += vecs[i].exp_words;
      check_output($sformatf("vec%0d_words", i), rx_q.size(), vecs[i].exp_words);
      if (vecs[i].exp_words == 1) check_word($sformatf("vec%0d_word", i), 0,
                                             vecs[i].exp_data, vecs[i].exp_keep);
      check_output($sformatf("vec%0d_reads", i), rd_pulses - base_rd, vecs[i].nbytes);
      check_output($sformatf("vec%0d_word_count", i), bus.word_count, exp_wc % 65536);
    end

    // Backpressure: second word waits in the accumulator, ninth byte stays queued.
    rx_q.delete();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) push(8'(k));
    run(20);
    check_output("bp_valid", bus.out_valid, 1);
    check_output("bp_data", bus.out_data, 32'h04030201);
    check_output("bp_keep", bus.out_keep, 4'hF);
    check_output("bp_read_en", bus.read_en, 0);
    check_output("bp_fifo_empty", bus.fifo_empty, 0);
    check_output("bp_fifo_left", fifo_q.size(), 1);
    bus.out_ready = 1'b1;
    run(15);
    exp_wc += 2;
    check_output("bp_words", rx_q.size(), 2);
    check_word("bp_word0", 0, 32'h04030201, 4'hF);
    check_word("bp_word1", 1, 32'h08070605, 4'hF);
    check_output("bp_word_count", bus.word_count, exp_wc % 65536);
    pulse_flush();
    run(6);
    exp_wc += 1;
    check_word("bp_tail", 2, 32'h00000009, 4'h1);

    // Empty FIFO with flush toggling: no pops and no words.
    for (int k = 0; k < 20; k++) begin
      bus.flush = k[0];
      tick();
      check_output("idle_read_en", bus.read_en, 0);
      check_output("idle_out_valid", bus.out_valid, 0);
    end
    bus.flush = 1'b0;

    // Mid-word reset discards captured bytes.
    push(8'hAA);
    push(8'hBB);
    run(8);
    rst = 1'b1;
    tick();
    check_output("mid_rst_read_en", bus.read_en, 0);
    check_output("mid_rst_out_valid", bus.out_valid, 0);
    check_output("mid_rst_out_data", bus.out_data, 0);
    check_output("mid_rst_out_keep", bus.out_keep, 0);
    check_output("mid_rst_word_count", bus.word_count, 0);
    rst = 1'b0;
    exp_wc = 0;
    rx_q.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    run(12);
    exp_wc += 1;
    check_output("post_rst_words", rx_q.size(), 1);
    check_word("post_rst_word", 0, 32'h44332211, 4'hF);
    check_output("post_rst_word_count", bus.word_count, exp_wc % 65536);

    // Flush lands while the third byte is still in flight.
    rx_q.delete();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    run(3);
    pulse_flush();
    run(8);
    exp_wc += 1;
    check_output("inflight_words", rx_q.size(), 1);
    check_word("inflight_word", 0, 32'h00C3C2C1, 4'h7);

    // Randomized traffic and backpressure; model groups bytes in arrival order.
    rx_q.delete();
    exp_bytes.delete();
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        rb = 8'($urandom);
        push(rb);
        exp_bytes.push_back(rb);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int t = 0; t < 200 && fifo_q.size() > 0; t++) tick();
    check_output("rand_drained", fifo_q.size(), 0);
    run(10);
    pulse_flush();
    run(8);
    n_exp = (exp_bytes.size() + PACK - 1) / PACK;
    check_output("rand_words", rx_q.size(), n_exp);
    for (int w = 0; w < n_exp; w++) begin
      d  = '0;
      kp = '0;
      for (int l = 0; l < PACK; l++) begin
        if (w * PACK + l < exp_bytes.size()) begin
          d[8*l +: 8] = exp_bytes[w * PACK + l];
          kp[l]       = 1'b1;
        end
      end
      check_word($sformatf("rand_word%0d", w), w, d, kp);
    end
    exp_wc += n_exp;
    check_output("rand_word_count", bus.word_count, exp_wc % 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
